// File: rtl/wave_pkg.sv
// Shared constants, state encoding and phase-increment clamp for the wave table player.
// Latency: none (declarations and a pure function only).
// Backpressure: not applicable.
package wave_pkg;

  localparam int BITWIDTH = 9;
  localparam int DEPTH    = 360;
  localparam int FRAC_W   = 8;
  localparam int IDX_W    = $clog2(DEPTH);
  localparam int PHASE_W  = IDX_W + FRAC_W;
  localparam int FREQ_W   = 9 + FRAC_W;
  localparam int FIDX_W   = FREQ_W - FRAC_W;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    READY = 2'd1,
    PLAY  = 2'd2
  } state_t;

  // Limit the integer part of the increment to DEPTH-1 so one wrap subtraction always suffices.
  function automatic logic [FREQ_W-1:0] clamp_freq(input logic [FREQ_W-1:0] fw);
    logic [FIDX_W-1:0] idx;
    idx = fw[FREQ_W-1:FRAC_W];
    if (idx >= FIDX_W'(DEPTH)) begin
      idx = FIDX_W'(DEPTH - 1);
    end
    return {idx, fw[FRAC_W-1:0]};
  endfunction

endpackage

// File: rtl/wave_ram.sv
// Waveform storage: one write port, one registered read port, DEPTH x BITWIDTH.
// Latency: read data appears 1 clock after rd_en.
// Backpressure: none; every enabled access completes in its cycle.
module wave_ram #(
  parameter int W  = 9,
  parameter int D  = 360,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_dat,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_dat
);

  logic [W-1:0] mem [D];
  logic [W-1:0] rd_dat_q;

  // Plain write/registered-read template so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
    if (rd_en) begin
      rd_dat_q <= mem[rd_addr];
    end
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/wave_table_player.sv
// Loads a waveform table from the initializer stream, then replays it via a DDS phase accumulator.
// Latency: out_v strobes 2 clocks after each prescaled tick; loaded rises the cycle after the last write.
// Backpressure: none; writes after the table is full are dropped and flagged on load_err.
// Optional PWM output stage is built when WAVE_PLAYER_PWM_EN is defined.
module wave_table_player
  import wave_pkg::*;
#(
  parameter int DIV = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BITWIDTH-1:0] in_data,
  input  logic                in_v,
  input  logic                in_done,
  input  logic                run,
  input  logic [FREQ_W-1:0]   freq_word,
  output logic [BITWIDTH-1:0] out_data,
  output logic                out_v,
  output logic                loaded,
  output logic                load_err
`ifdef WAVE_PLAYER_PWM_EN
  ,
  output logic                pwm_out
`endif
);

  localparam int CNT_W = $clog2(DIV);
  localparam int SUM_W = PHASE_W + 1;
  localparam logic [SUM_W-1:0] WRAP = SUM_W'(DEPTH) << FRAC_W;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     wr_addr_q, wr_addr_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 rd_pend_q, rd_pend_d;
  logic [BITWIDTH-1:0]  out_data_q, out_data_d;
  logic                 out_v_q, out_v_d;
  logic                 loaded_q, loaded_d;
  logic                 load_err_q, load_err_d;

  logic                 tick;
  logic                 wr_en;
  logic [SUM_W-1:0]     phase_sum;
  logic [BITWIDTH-1:0]  ram_dat;

  assign tick      = (state_q == PLAY) && (cnt_q == CNT_W'(DIV - 1));
  assign wr_en     = (state_q == LOAD) && in_v;
  assign phase_sum = SUM_W'(phase_q) + SUM_W'(clamp_freq(freq_word));

  // The read address is the phase index at the tick, so the first sample played is the current entry.
  wave_ram #(
    .W  (BITWIDTH),
    .D  (DEPTH),
    .AW (IDX_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr_q),
    .wr_dat  (in_data),
    .rd_en   (tick),
    .rd_addr (phase_q[PHASE_W-1:FRAC_W]),
    .rd_dat  (ram_dat)
  );

  // Next-state logic for the load/ready/play sequencer, accumulator and output register.
  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    loaded_d   = loaded_q;
    load_err_d = load_err_q;
    rd_pend_d  = tick;
    out_v_d    = rd_pend_q;
    out_data_d = rd_pend_q ? ram_dat : out_data_q;
    case (state_q)
      LOAD: begin
        if (in_v) begin
          wr_addr_d = wr_addr_q + IDX_W'(1);
          if (wr_addr_q == IDX_W'(DEPTH - 1)) begin
            state_d  = READY;
            loaded_d = 1'b1;
          end
        end else if (in_done) begin
          // Producer claims completion but the table is still short.
          load_err_d = 1'b1;
        end
      end
      READY: begin
        if (in_v) load_err_d = 1'b1;
        if (run)  state_d    = PLAY;
      end
      PLAY: begin
        if (in_v) load_err_d = 1'b1;
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        if (tick) begin
          phase_d = (phase_sum >= WRAP) ? PHASE_W'(phase_sum - WRAP) : PHASE_W'(phase_sum);
        end
        if (!run) state_d = READY;
      end
      default: state_d = LOAD;
    endcase
  end

  // State registers with synchronous reset back to an empty table.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOAD;
      wr_addr_q  <= '0;
      phase_q    <= '0;
      cnt_q      <= '0;
      rd_pend_q  <= 1'b0;
      out_data_q <= '0;
      out_v_q    <= 1'b0;
      loaded_q   <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      rd_pend_q  <= rd_pend_d;
      out_data_q <= out_data_d;
      out_v_q    <= out_v_d;
      loaded_q   <= loaded_d;
      load_err_q <= load_err_d;
    end
  end

  assign out_data = out_data_q;
  assign out_v    = out_v_q;
  assign loaded   = loaded_q;
  assign load_err = load_err_q;

`ifdef WAVE_PLAYER_PWM_EN
  logic [BITWIDTH-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [BITWIDTH-1:0] cmp_q, cmp_d;
  logic                pwm_q, pwm_d;

  // Compare value only changes at counter wrap so each PWM period is glitch-free.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + BITWIDTH'(1);
    cmp_d     = (pwm_cnt_q == '1) ? out_data_q : cmp_q;
    pwm_d     = (pwm_cnt_q < cmp_q);
  end

  // Free-running PWM counter, compare latch and output flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q <= '0;
      cmp_q     <= '0;
      pwm_q     <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      cmp_q     <= cmp_d;
      pwm_q     <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;
`endif

endmodule
